// File: rtl/autoconfig_chain.sv
// autoconfig_chain
//
// Presents NUM_BOARDS logical Zorro autoconfig boards one after another on a
// single physical slot. Only the board selected by the internal pointer
// answers; once it is given a base address (0x48) or told to shut up (0x4C)
// the pointer moves on. When the last board is done the chain reports
// CONFIGURED and passes the enable on through CONFIGENn.
//
// Ports
//   CLK40            in   system clock
//   RESETn           in   synchronous reset, active low
//   AUTOCONFIG_SPACE in   address decode hit on the autoconfig window
//   RnW              in   1 = read, 0 = write
//   TSn              in   transfer start, active low
//   A[7:1]           in   register offset (byte offset = {A, 1'b0})
//   D_IN[3:0]        in   write nibble (D31-D28)
//   D_OUT[3:0]       out  read nibble, held until the next read
//   AC_TACK          out  one-cycle transfer acknowledge
//   CPUCONFn         in   chain enable from upstream, active low
//   CONFIGENn        out  chain enable to downstream, active low
//   CONFIGURED       out  all boards configured or shut up
//   BOARD_CFG        out  per-board "base address assigned"
//   BOARD_SHUT       out  per-board "shut up"
//   BASE             out  per-board base byte, board 0 in the low byte
module autoconfig_chain #(
    parameter int                         NUM_BOARDS = 3,
    parameter logic [8*NUM_BOARDS-1:0]    ER_TYPE    = {8'hC1, 8'hD2, 8'h84},
    parameter logic [8*NUM_BOARDS-1:0]    PRODUCT    = {8'd200, 8'd3, 8'd4},
    parameter logic [16*NUM_BOARDS-1:0]   MFG        = {16'd3643, 16'd600, 16'd600},
    parameter logic [32*NUM_BOARDS-1:0]   SERIAL     = {3{32'd1}},
    parameter logic [4*NUM_BOARDS-1:0]    FLAGS      = {3{4'h0}}
) (
    input  logic                      CLK40,
    input  logic                      RESETn,
    input  logic                      AUTOCONFIG_SPACE,
    input  logic                      RnW,
    input  logic                      TSn,
    input  logic [7:1]                A,
    input  logic [3:0]                D_IN,
    output logic [3:0]                D_OUT,
    output logic                      AC_TACK,
    input  logic                      CPUCONFn,
    output logic                      CONFIGENn,
    output logic                      CONFIGURED,
    output logic [NUM_BOARDS-1:0]     BOARD_CFG,
    output logic [NUM_BOARDS-1:0]     BOARD_SHUT,
    output logic [8*NUM_BOARDS-1:0]   BASE
);

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    localparam logic [1:0] LAST = 2'(NUM_BOARDS - 1);

    state_t     state;
    logic [1:0] ptr;
    logic       start;
    logic [7:0] offset;

    assign offset = {A, 1'b0};

    // Register file of one board. Only er_type is presented true; every other
    // defined field is returned inverted, as autoconfig requires.
    function automatic logic [3:0] rd_nibble(input logic [7:0] off, input logic [1:0] b);
        int          bi;
        logic [7:0]  er;
        logic [7:0]  prod;
        logic [3:0]  flg;
        logic [15:0] mfg;
        logic [31:0] ser;
        bi   = (int'(b) < NUM_BOARDS) ? int'(b) : NUM_BOARDS - 1;
        er   = ER_TYPE[bi*8 +: 8];
        prod = PRODUCT[bi*8 +: 8];
        flg  = FLAGS[bi*4 +: 4];
        mfg  = MFG[bi*16 +: 16];
        ser  = SERIAL[bi*32 +: 32];
        if (off >= 8'h10 && off <= 8'h16)
            return ~mfg[(3 - int'((off - 8'h10) >> 1))*4 +: 4];
        if (off >= 8'h18 && off <= 8'h26)
            return ~ser[(7 - int'((off - 8'h18) >> 1))*4 +: 4];
        case (off)
            8'h00:   return er[7:4];
            8'h02:   return er[3:0];
            8'h04:   return ~prod[7:4];
            8'h06:   return ~prod[3:0];
            8'h08:   return ~flg;
            default: return 4'hF;
        endcase
    endfunction

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            start      <= 1'b0;
            AC_TACK    <= 1'b0;
            D_OUT      <= 4'h0;
            BASE       <= '0;
            BOARD_CFG  <= '0;
            BOARD_SHUT <= '0;
            CONFIGURED <= 1'b0;
            CONFIGENn  <= 1'b1;
        end else begin
            // Transfer start is registered once; the FSM never looks at TSn.
            start   <= !CONFIGURED && AUTOCONFIG_SPACE && !TSn;
            AC_TACK <= 1'b0;
            case (state)
                IDLE: begin
                    // A start seen while not idle is simply dropped.
                    if (start && !CPUCONFn && !CONFIGURED)
                        state <= RnW ? RD : WR;
                end
                RD: begin
                    D_OUT   <= rd_nibble(offset, ptr);
                    AC_TACK <= 1'b1;
                    state   <= ACK;
                end
                WR: begin
                    AC_TACK <= 1'b1;
                    state   <= ACK;
                    case (offset)
                        8'h4A: BASE[int'(ptr)*8 +: 4] <= D_IN;
                        8'h48, 8'h4C: begin
                            if (offset == 8'h48) begin
                                BASE[int'(ptr)*8 + 4 +: 4] <= D_IN;
                                BOARD_CFG[ptr]             <= 1'b1;
                            end else begin
                                BOARD_SHUT[ptr]            <= 1'b1;
                            end
                            // Pointer saturates on the last board; the chain
                            // is finished instead of wrapping around.
                            if (ptr == LAST) begin
                                CONFIGURED <= 1'b1;
                                CONFIGENn  <= 1'b0;
                                D_OUT      <= 4'hF;
                            end else begin
                                ptr <= ptr + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_autoconfig_chain.sv
// tb_autoconfig_chain
//
// Directed bench for autoconfig_chain. Board 0 carries er_type 0xC1 and
// board 2 carries 0x84 so that board order in the packed parameters is
// visible in the read data. Expected values are written out by hand.
module tb_autoconfig_chain;

    logic        clk40 = 1'b0;
    logic        resetn;
    logic        space;
    logic        rnw;
    logic        tsn;
    logic [7:1]  a;
    logic [3:0]  d_in;
    logic [3:0]  d_out;
    logic        ac_tack;
    logic        cpuconfn;
    logic        configenn;
    logic        configured;
    logic [2:0]  board_cfg;
    logic [2:0]  board_shut;
    logic [23:0] base;

    int total = 0;
    int bad   = 0;
    int lat;

    autoconfig_chain #(
        .NUM_BOARDS (3),
        .ER_TYPE    ({8'h84, 8'hD2, 8'hC1})
    ) dut (
        .CLK40            (clk40),
        .RESETn           (resetn),
        .AUTOCONFIG_SPACE (space),
        .RnW              (rnw),
        .TSn              (tsn),
        .A                (a),
        .D_IN             (d_in),
        .D_OUT            (d_out),
        .AC_TACK          (ac_tack),
        .CPUCONFn         (cpuconfn),
        .CONFIGENn        (configenn),
        .CONFIGURED       (configured),
        .BOARD_CFG        (board_cfg),
        .BOARD_SHUT       (board_shut),
        .BASE             (base)
    );

    always #10 clk40 = ~clk40;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle; lat = cycles from the START edge to AC_TACK, 99 if none
    // within the window.
    task automatic bus(input logic r, input logic [7:0] off, input logic [3:0] din,
                       output int l);
        @(negedge clk40);
        space = 1'b1;
        rnw   = r;
        a     = off[7:1];
        d_in  = din;
        tsn   = 1'b0;
        @(posedge clk40);
        #1 tsn = 1'b1;
        l = 99;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk40);
            #1;
            if (ac_tack && l == 99) l = i;
        end
        space = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] off, input logic [3:0] exp);
        int l;
        bus(1'b1, off, 4'h0, l);
        check({tag, "_lat"}, l, 2);
        check(tag, d_out, exp);
    endtask

    task automatic do_reset();
        @(negedge clk40);
        resetn = 1'b0;
        repeat (3) @(posedge clk40);
        #1 resetn = 1'b1;
    endtask

    initial begin
        resetn   = 1'b0;
        space    = 1'b0;
        rnw      = 1'b1;
        tsn      = 1'b1;
        a        = '0;
        d_in     = '0;
        cpuconfn = 1'b0;
        repeat (3) @(posedge clk40);
        #1;
        check("rst_dout", d_out, 4'h0);
        check("rst_tack", ac_tack, 1'b0);
        check("rst_configured", configured, 1'b0);
        check("rst_configenn", configenn, 1'b1);
        check("rst_base", base, 24'h0);
        check("rst_cfg", board_cfg, 3'b000);
        check("rst_shut", board_shut, 3'b000);
        resetn = 1'b1;

        // Board 0 register file
        rd("b0_r00", 8'h00, 4'hC);
        rd("b0_r02", 8'h02, 4'h1);
        rd("b0_r04", 8'h04, 4'hF);
        rd("b0_r06", 8'h06, 4'hB);
        rd("b0_r08", 8'h08, 4'hF);
        rd("b0_r10", 8'h10, 4'hF);
        rd("b0_r12", 8'h12, 4'hD);
        rd("b0_r14", 8'h14, 4'hA);
        rd("b0_r16", 8'h16, 4'h7);
        rd("b0_r18", 8'h18, 4'hF);
        rd("b0_r26", 8'h26, 4'hE);
        rd("b0_r30", 8'h30, 4'hF);

        // Base address for board 0: low nibble, then commit
        bus(1'b0, 8'h4A, 4'h5, lat);
        check("w4a_lat", lat, 2);
        check("w4a_nocommit", board_cfg, 3'b000);
        bus(1'b0, 8'h48, 4'hE, lat);
        check("w48_lat", lat, 2);
        check("b0_base", base[7:0], 8'hE5);
        check("b0_cfg", board_cfg, 3'b001);
        rd("b1_r02", 8'h02, 4'h2);
        rd("b1_r00", 8'h00, 4'hD);

        // Write elsewhere only completes the handshake
        bus(1'b0, 8'h40, 4'h7, lat);
        check("w40_lat", lat, 2);
        check("w40_base", base, 24'h0000E5);
        check("w40_cfg", board_cfg, 3'b001);

        // Upstream chain not enabled: nothing answers
        cpuconfn = 1'b1;
        bus(1'b1, 8'h02, 4'h0, lat);
        check("dis_notack", lat, 99);
        check("dis_dout", d_out, 4'hD);
        bus(1'b0, 8'h48, 4'h9, lat);
        check("dis_wr_notack", lat, 99);
        check("dis_base", base, 24'h0000E5);
        check("dis_cfg", board_cfg, 3'b001);
        cpuconfn = 1'b0;

        // Board 1 shuts up
        bus(1'b0, 8'h4C, 4'h3, lat);
        check("w4c_lat", lat, 2);
        check("b1_shut", board_shut, 3'b010);
        check("b1_base", base[15:8], 8'h00);
        check("b1_cfg", board_cfg, 3'b001);
        rd("b2_r00", 8'h00, 4'h8);
        rd("b2_r02", 8'h02, 4'h4);

        // Board 2 is the last one
        bus(1'b0, 8'h4A, 4'h1, lat);
        check("b2_w4a_lat", lat, 2);
        check("b2_pre_configured", configured, 1'b0);
        bus(1'b0, 8'h48, 4'h4, lat);
        check("b2_w48_lat", lat, 2);
        check("done_configured", configured, 1'b1);
        check("done_configenn", configenn, 1'b0);
        check("done_dout", d_out, 4'hF);
        check("done_base", base, 24'h4100E5);
        check("done_cfg", board_cfg, 3'b101);
        check("done_shut", board_shut, 3'b010);
        bus(1'b1, 8'h00, 4'h0, lat);
        check("done_notack", lat, 99);
        check("done_dout_after", d_out, 4'hF);

        // Reset in the middle of a 0x48 write
        do_reset();
        check("re_configured", configured, 1'b0);
        check("re_configenn", configenn, 1'b1);
        @(negedge clk40);
        space = 1'b1;
        rnw   = 1'b0;
        a     = 7'h24;
        d_in  = 4'hA;
        tsn   = 1'b0;
        @(posedge clk40);
        #1 tsn = 1'b1;
        @(posedge clk40);
        #1 resetn = 1'b0;
        @(posedge clk40);
        #1;
        check("mid_tack", ac_tack, 1'b0);
        check("mid_cfg", board_cfg, 3'b000);
        check("mid_base", base, 24'h0);
        space  = 1'b0;
        resetn = 1'b1;
        lat = 99;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk40);
            #1;
            if (ac_tack && lat == 99) lat = i;
        end
        check("mid_notack_after", lat, 99);
        check("mid_cfg_after", board_cfg, 3'b000);

        // Fresh chain answers again from board 0
        rd("post_r00", 8'h00, 4'hC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
